// File: rtl/fpu_double.sv
// IEEE-754 binary64 add/sub/mul/div unit with four rounding modes.
// One operation per accepted enable; result and flags appear a fixed 60 cycles later.
module fpu_double (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  rmode,
  input  logic [2:0]  fpu_op,
  input  logic [63:0] opa,
  input  logic [63:0] opb,
  output logic [63:0] out,
  output logic        ready,
  output logic        underflow,
  output logic        overflow,
  output logic        inexact,
  output logic        exception,
  output logic        invalid
);
  localparam int unsigned LATENCY  = 60;
  localparam int unsigned CW       = 6;
  localparam int unsigned MD_STEPS = 57;
  localparam logic [63:0] QNAN     = 64'h7FF8_0000_0000_0000;
  localparam logic [62:0] INF      = {11'h7FF, 52'd0};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic          armed;
  logic          start;

  // Next-state: BUSY runs the iterative units, DONE registers the rounded result
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      IDLE: if (enable && armed) begin
        start    = 1'b1;
        state_nx = BUSY;
      end
      BUSY: if (cnt == CW'(LATENCY - 2)) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // armed blocks a held enable from launching a second operation
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      armed <= 1'b1;
    end else begin
      if (start)        armed <= 1'b0;
      else if (!enable) armed <= 1'b1;
      cnt <= (state == BUSY) ? cnt + CW'(1) : '0;
    end
  end

  logic [63:0] a_r, b_r;
  logic [2:0]  op_r;
  logic [1:0]  rm_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_r  <= '0;
      b_r  <= '0;
      op_r <= '0;
      rm_r <= '0;
    end else if (start) begin
      a_r  <= opa;
      b_r  <= opb;
      op_r <= fpu_op;
      rm_r <= rmode;
    end
  end

  logic        sa, sb, sbe;
  logic [10:0] ea, eb;
  logic [51:0] fa, fb;
  logic [52:0] ma, mb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic [62:0] ka, kb;

  assign sa     = a_r[63];
  assign ea     = a_r[62:52];
  assign fa     = a_r[51:0];
  assign sb     = b_r[63];
  assign eb     = b_r[62:52];
  assign fb     = b_r[51:0];
  assign sbe    = sb ^ (op_r[1:0] == 2'b01);
  assign a_zero = (ea == 11'd0);
  assign b_zero = (eb == 11'd0);
  assign a_inf  = (ea == 11'h7FF) && (fa == 52'd0);
  assign b_inf  = (eb == 11'h7FF) && (fb == 52'd0);
  assign a_nan  = (ea == 11'h7FF) && (fa != 52'd0);
  assign b_nan  = (eb == 11'h7FF) && (fb != 52'd0);
  assign a_snan = a_nan && !fa[51];
  assign b_snan = b_nan && !fb[51];
  // Denormals collapse to signed zero everywhere
  assign ma     = a_zero ? 53'd0 : {1'b1, fa};
  assign mb     = b_zero ? 53'd0 : {1'b1, fb};
  assign ka     = a_zero ? 63'd0 : a_r[62:0];
  assign kb     = b_zero ? 63'd0 : b_r[62:0];

  // Shift-add multiplier and restoring divider share the BUSY window
  logic [105:0] prod, mcand;
  logic [52:0]  mplier;
  logic [54:0]  rem;
  logic [56:0]  quo;
  logic [55:0]  rem_diff;

  assign rem_diff = {1'b0, rem} - {3'b000, mb};

  always_ff @(posedge clk) begin
    if (state == BUSY) begin
      if (cnt == '0) begin
        prod   <= '0;
        mcand  <= {53'd0, ma};
        mplier <= mb;
        rem    <= {2'b00, ma};
        quo    <= '0;
      end else if (cnt <= CW'(MD_STEPS)) begin
        if (mplier[0]) prod <= prod + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        quo    <= {quo[55:0], !rem_diff[55]};
        rem    <= rem_diff[55] ? (rem << 1) : (rem_diff[54:0] << 1);
      end
    end
  end

  function automatic logic [5:0] lzc(input logic [55:0] v);
    logic found;
    lzc   = '0;
    found = 1'b0;
    for (int i = 55; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      lzc   = lzc + 6'd1;
      end
    end
  endfunction

  logic        a_ge, l_s, st_a, add_zero;
  logic [10:0] l_e, s_e, d;
  logic [52:0] l_m, s_m;
  logic [55:0] s_ext, al, add_m;
  logic [56:0] sum;
  logic [5:0]  lz;
  logic [12:0] add_e;

  // Add/sub: align smaller magnitude with guard/round/sticky, combine, normalise
  always_comb begin
    a_ge  = (ka >= kb);
    l_e   = a_ge ? ka[62:52] : kb[62:52];
    s_e   = a_ge ? kb[62:52] : ka[62:52];
    l_m   = a_ge ? ma : mb;
    s_m   = a_ge ? mb : ma;
    l_s   = a_ge ? sa : sbe;
    d     = l_e - s_e;
    s_ext = {s_m, 3'b000};
    if (d >= 11'd56) begin
      al   = '0;
      st_a = |s_ext;
    end else begin
      al   = s_ext >> d;
      st_a = |(s_ext & ~({56{1'b1}} << d));
    end
    al[0] = al[0] | st_a;
    if (sa == sbe) sum = {1'b0, l_m, 3'b000} + {1'b0, al};
    else           sum = {1'b0, l_m, 3'b000} - {1'b0, al};
    lz       = lzc(sum[55:0]);
    add_zero = (sum == 57'd0);
    if (sum[56]) begin
      add_m = {sum[56:2], sum[1] | sum[0]};
      add_e = 13'(l_e) + 13'd1;
    end else begin
      add_m = sum[55:0] << lz;
      add_e = 13'(l_e) - 13'(lz);
    end
  end

  logic        md_s;
  logic [55:0] md_m;
  logic [12:0] md_e;

  always_comb begin
    md_s = sa ^ sb;
    if (!op_r[0]) begin
      if (prod[105]) begin
        md_m = {prod[105:51], |prod[50:0]};
        md_e = 13'(ea) + 13'(eb) - 13'd1022;
      end else begin
        md_m = {prod[104:50], |prod[49:0]};
        md_e = 13'(ea) + 13'(eb) - 13'd1023;
      end
    end else begin
      if (quo[56]) begin
        md_m = {quo[56:2], (|quo[1:0]) | (|rem)};
        md_e = 13'(ea) - 13'(eb) + 13'd1023;
      end else begin
        md_m = {quo[55:1], quo[0] | (|rem)};
        md_e = 13'(ea) - 13'(eb) + 13'd1022;
      end
    end
  end

  logic        spec_hit, spec_inv, spec_dz;
  logic [63:0] spec_out;

  // Infinity and zero operand cases that bypass the arithmetic path
  always_comb begin
    spec_hit = 1'b0;
    spec_inv = 1'b0;
    spec_dz  = 1'b0;
    spec_out = QNAN;
    case (op_r[1:0])
      2'b00, 2'b01: begin
        if (a_inf && b_inf && (sa != sbe)) begin
          spec_hit = 1'b1;
          spec_inv = 1'b1;
        end else if (a_inf) begin
          spec_hit = 1'b1;
          spec_out = {sa, INF};
        end else if (b_inf) begin
          spec_hit = 1'b1;
          spec_out = {sbe, INF};
        end
      end
      2'b10: begin
        if ((a_inf && b_zero) || (b_inf && a_zero)) begin
          spec_hit = 1'b1;
          spec_inv = 1'b1;
        end else if (a_inf || b_inf) begin
          spec_hit = 1'b1;
          spec_out = {md_s, INF};
        end else if (a_zero || b_zero) begin
          spec_hit = 1'b1;
          spec_out = {md_s, 63'd0};
        end
      end
      default: begin
        if ((a_zero && b_zero) || (a_inf && b_inf)) begin
          spec_hit = 1'b1;
          spec_inv = 1'b1;
        end else if (a_inf) begin
          spec_hit = 1'b1;
          spec_out = {md_s, INF};
        end else if (b_inf || a_zero) begin
          spec_hit = 1'b1;
          spec_out = {md_s, 63'd0};
        end else if (b_zero) begin
          spec_hit = 1'b1;
          spec_dz  = 1'b1;
          spec_out = {md_s, INF};
        end
      end
    endcase
  end

  logic        is_add, n_s, g, st, inx, up, to_inf, zs;
  logic [55:0] n_m;
  logic [12:0] n_e, e_r;
  logic [53:0] sig;
  logic [51:0] frac;
  logic [63:0] r_out;
  logic        r_inv, r_ovf, r_unf, r_inx, r_dz;

  // Round, then resolve specials, zero, underflow and overflow in priority order
  always_comb begin
    is_add = (op_r[2:1] == 2'b00);
    n_s    = is_add ? l_s : md_s;
    n_m    = is_add ? add_m : md_m;
    n_e    = is_add ? add_e : md_e;
    g      = n_m[2];
    st     = |n_m[1:0];
    inx    = g | st;
    case (rm_r)
      2'b00:   up = g & (st | n_m[3]);
      2'b01:   up = 1'b0;
      2'b10:   up = inx & !n_s;
      default: up = inx & n_s;
    endcase
    sig    = {1'b0, n_m[55:3]} + 54'(up);
    e_r    = n_e + 13'(sig[53]);
    frac   = sig[53] ? sig[52:1] : sig[51:0];
    to_inf = (rm_r == 2'b00) || ((rm_r == 2'b10) && !n_s) || ((rm_r == 2'b11) && n_s);
    zs     = (sa == sbe) ? sa : (rm_r == 2'b11);
    r_out  = {n_s, e_r[10:0], frac};
    r_inv  = 1'b0;
    r_ovf  = 1'b0;
    r_unf  = 1'b0;
    r_inx  = inx;
    r_dz   = 1'b0;
    if (op_r[2]) begin
      r_out = QNAN;
      r_inv = 1'b1;
      r_inx = 1'b0;
    end else if (a_nan || b_nan) begin
      r_out = QNAN;
      r_inv = a_snan | b_snan;
      r_inx = 1'b0;
    end else if (spec_hit) begin
      r_out = spec_out;
      r_inv = spec_inv;
      r_dz  = spec_dz;
      r_inx = 1'b0;
    end else if (is_add && add_zero) begin
      r_out = {zs, 63'd0};
      r_inx = 1'b0;
    end else if ($signed(n_e) < 13'sd1) begin
      r_out = {n_s, 63'd0};
      r_unf = 1'b1;
      r_inx = 1'b1;
    end else if ($signed(e_r) > 13'sd2046) begin
      r_out = to_inf ? {n_s, INF} : {n_s, 11'h7FE, {52{1'b1}}};
      r_ovf = 1'b1;
      r_inx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out       <= '0;
      ready     <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
      inexact   <= 1'b0;
      exception <= 1'b0;
      invalid   <= 1'b0;
    end else if (start) begin
      ready     <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
      inexact   <= 1'b0;
      exception <= 1'b0;
      invalid   <= 1'b0;
    end else if (state == DONE) begin
      out       <= r_out;
      ready     <= 1'b1;
      underflow <= r_unf;
      overflow  <= r_ovf;
      inexact   <= r_inx;
      invalid   <= r_inv;
      exception <= r_inv | r_ovf | r_unf | r_dz;
    end
  end
endmodule

// File: tb/tb_fpu_double.sv
// Scoreboard bench for fpu_double: expected results queued at issue, compared when ready rises.
module tb_fpu_double;
  localparam logic [2:0]  ADD = 3'b000, SUB = 3'b001, MUL = 3'b010, DIV = 3'b011, BAD = 3'b100;
  localparam logic [1:0]  RNE = 2'b00, RZ = 2'b01, RUP = 2'b10, RDN = 2'b11;
  localparam logic [63:0] ZERO  = 64'h0000_0000_0000_0000;
  localparam logic [63:0] NZERO = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONE   = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] TWO   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] THREE = 64'h4008_0000_0000_0000;
  localparam logic [63:0] SIX   = 64'h4018_0000_0000_0000;
  localparam logic [63:0] ONEP5 = 64'h3FF8_0000_0000_0000;
  localparam logic [63:0] HALF  = 64'h3FE0_0000_0000_0000;
  localparam logic [63:0] MAXF  = 64'h7FEF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN  = 64'h0010_0000_0000_0000;
  localparam logic [63:0] PINF  = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] QNAN  = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] SNAN  = 64'h7FF0_0000_0000_0001;
  localparam logic [4:0]  F_UNF = 5'd1, F_OVF = 5'd2, F_INX = 5'd4, F_EXC = 5'd8, F_INV = 5'd16;

  logic        clk = 1'b0, rst = 1'b0, enable = 1'b0;
  logic [1:0]  rmode = '0;
  logic [2:0]  fpu_op = '0;
  logic [63:0] opa = '0, opb = '0, out;
  logic        ready, underflow, overflow, inexact, exception, invalid;

  fpu_double dut (
    .clk(clk), .rst(rst), .enable(enable), .rmode(rmode), .fpu_op(fpu_op),
    .opa(opa), .opb(opb), .out(out), .ready(ready), .underflow(underflow),
    .overflow(overflow), .inexact(inexact), .exception(exception), .invalid(invalid)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    logic [63:0] res;
    logic [4:0]  flags;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned acc_cyc = 0;

  function automatic logic [4:0] flags_now();
    return {invalid, exception, inexact, overflow, underflow};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] op, input logic [1:0] rm, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] eo, input logic [4:0] ef,
                          input string tag, input int hold);
    exp_t e;
    e.tag = tag;
    e.res = eo;
    e.flags = ef;
    sb.push_back(e);
    @(negedge clk);
    fpu_op = op; rmode = rm; opa = a; opb = b; enable = 1'b1;
    @(posedge clk);
    #1 acc_cyc = cyc;
    for (int i = 1; i < hold; i++) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_result();
    exp_t e;
    bit   got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #1;
      if (ready) got = 1'b1;
    end
    e = sb.pop_front();
    check({e.tag, "_ready"}, 64'(ready), 64'd1);
    if (got) begin
      check({e.tag, "_latency"}, 64'(cyc - acc_cyc), 64'd60);
      check({e.tag, "_out"}, out, e.res);
      check({e.tag, "_flags"}, 64'(flags_now()), 64'(e.flags));
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [1:0] rm, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] eo, input logic [4:0] ef,
                     input string tag);
    start_op(op, rm, a, b, eo, ef, tag, 1);
    wait_result();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", out, ZERO);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_flags", 64'(flags_now()), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run(ADD, RNE, ONE, TWO, THREE, 5'd0, "add_1p2");
    run(MUL, RNE, THREE, 64'hC000_0000_0000_0000, 64'hC018_0000_0000_0000, 5'd0, "mul_3xm2");
    run(DIV, RNE, ONE, THREE, 64'h3FD5_5555_5555_5555, F_INX, "div_1d3");
    run(SUB, RNE, ONE, ONE, ZERO, 5'd0, "sub_rne_zero");
    run(SUB, RDN, ONE, ONE, NZERO, 5'd0, "sub_rdn_zero");
    run(ADD, RNE, NZERO, NZERO, NZERO, 5'd0, "add_negzeros");
    run(SUB, RNE, ONE, 64'h3FE8_0000_0000_0000, 64'h3FD0_0000_0000_0000, 5'd0, "sub_norm");
    run(MUL, RNE, MAXF, TWO, PINF, F_OVF | F_INX | F_EXC, "ovf_rne");
    run(MUL, RZ, MAXF, TWO, MAXF, F_OVF | F_INX | F_EXC, "ovf_rz");
    run(DIV, RNE, ZERO, ZERO, QNAN, F_INV | F_EXC, "div_0d0");
    run(MUL, RNE, MINN, HALF, ZERO, F_UNF | F_INX | F_EXC, "unf_flush");
    run(BAD, RNE, ONE, ONE, QNAN, F_INV | F_EXC, "bad_op");
    run(DIV, RNE, ONE, ZERO, PINF, F_EXC, "div_by_zero");
    run(ADD, RNE, SNAN, ONE, QNAN, F_INV | F_EXC, "snan_in");
    run(ADD, RNE, QNAN, ONE, QNAN, 5'd0, "qnan_in");
    run(SUB, RNE, PINF, PINF, QNAN, F_INV | F_EXC, "inf_m_inf");
    run(DIV, RNE, ONE, PINF, ZERO, 5'd0, "fin_d_inf");
    run(ADD, RNE, ONE, 64'h3CA0_0000_0000_0000, ONE, F_INX, "tie_rne");
    run(ADD, RUP, ONE, 64'h3CA0_0000_0000_0000, 64'h3FF0_0000_0000_0001, F_INX, "tie_rup");
    run(MUL, RNE, ONEP5, ONEP5, 64'h4002_0000_0000_0000, 5'd0, "mul_carry");
    run(DIV, RNE, SIX, TWO, THREE, 5'd0, "div_6d2");

    // Enable held four cycles launches exactly one operation
    start_op(ADD, RNE, ONE, TWO, THREE, 5'd0, "hold4", 4);
    wait_result();
    repeat (5) @(posedge clk);
    #1;
    check("hold4_ready_held", 64'(ready), 64'd1);
    check("hold4_out_held", out, THREE);

    // A pulse while busy is ignored and does not start a later operation
    start_op(MUL, RNE, ONEP5, ONEP5, 64'h4002_0000_0000_0000, 5'd0, "midbusy", 1);
    repeat (20) @(negedge clk);
    fpu_op = ADD; opa = SIX; opb = SIX; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_result();
    repeat (70) @(posedge clk);
    #1;
    check("midbusy_ready_held", 64'(ready), 64'd1);
    check("midbusy_out_held", out, 64'h4002_0000_0000_0000);

    // Reset in flight aborts the operation and clears the result
    @(negedge clk);
    fpu_op = DIV; rmode = RNE; opa = SIX; opb = TWO; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_ready", 64'(ready), 64'd0);
    check("rst_mid_out", out, ZERO);
    @(negedge clk);
    rst = 1'b1;
    repeat (70) @(posedge clk);
    #1;
    check("rst_mid_aborted", 64'(ready), 64'd0);

    run(ADD, RNE, ONE, TWO, THREE, 5'd0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
